// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Write-back stage of the arithmetic/compare unit. Each lane has one holding
// register for its result. Held results go out on the common data bus one per
// cycle. A round-robin pointer picks which lane goes next.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous reset, active low
//   flush_i      discards every held result and drops this cycle's inputs
//   in_valid_i   per lane: a result is presented
//   in_tag_i     per lane: ROB tag of the presented result
//   in_data_i    per lane: value of the presented result
//   in_ready_o   per lane: the presented result is captured at this edge
//   cdb_valid_o  a broadcast is present
//   cdb_tag_o    tag of the broadcast (0 when idle)
//   cdb_data_o   value of the broadcast (0 when idle)
//   cdb_lane_o   source lane of the broadcast (0 when idle)
//   cdb_ready_i  the consumer accepts the broadcast
//   pending_o    registered count of occupied holding registers
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int SIZE   = 15,
  parameter  int TAG_W  = 4,
  parameter  int DATA_W = 32,
  localparam int LANE_W = $clog2(SIZE),
  localparam int CNT_W  = $clog2(SIZE + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [SIZE-1:0]   in_valid_i,
  input  logic [TAG_W-1:0]  in_tag_i  [SIZE],
  input  logic [DATA_W-1:0] in_data_i [SIZE],
  output logic [SIZE-1:0]   in_ready_o,
  output logic              cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [LANE_W-1:0] cdb_lane_o,
  input  logic              cdb_ready_i,
  output logic [CNT_W-1:0]  pending_o
);

  logic [SIZE-1:0]   hold_v_q, hold_v_d;
  logic [TAG_W-1:0]  hold_tag_q  [SIZE];
  logic [DATA_W-1:0] hold_data_q [SIZE];
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  pending_q, pending_d;

  logic [SIZE-1:0]   capture;
  logic [SIZE-1:0]   take;
  logic [LANE_W-1:0] sel;
  logic              sel_found;
  logic [LANE_W:0]   scan_idx;
  logic              take_any;

  // Search from rr_ptr upward and wrap at SIZE-1. scan_idx has one spare bit
  // so that rr_ptr + k cannot overflow before it is wrapped.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < SIZE; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (LANE_W+1)'(k);
      if (scan_idx >= (LANE_W+1)'(SIZE)) begin
        scan_idx = scan_idx - (LANE_W+1)'(SIZE);
      end
      if (!sel_found && hold_v_q[scan_idx[LANE_W-1:0]]) begin
        sel_found = 1'b1;
        sel       = scan_idx[LANE_W-1:0];
      end
    end
  end

  assign cdb_valid_o = (|hold_v_q) & ~flush_i;
  assign take_any    = cdb_valid_o & cdb_ready_i;

  always_comb begin
    take = '0;
    if (take_any) begin
      take[sel] = 1'b1;
    end
  end

  // A lane being taken this cycle can refill at the same edge. cdb_ready
  // reaches in_ready through take. in_valid never feeds in_ready.
  assign in_ready_o = {SIZE{rst_i & ~flush_i}} & (~hold_v_q | take);

  always_comb begin
    cdb_tag_o  = '0;
    cdb_data_o = '0;
    cdb_lane_o = '0;
    if (cdb_valid_o) begin
      cdb_tag_o  = hold_tag_q[sel];
      cdb_data_o = hold_data_q[sel];
      cdb_lane_o = sel;
    end
  end

  always_comb begin
    hold_v_d = hold_v_q;
    capture  = '0;
    rr_ptr_d = rr_ptr_q;
    if (!rst_i || flush_i) begin
      hold_v_d = '0;
      rr_ptr_d = '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (in_valid_i[i] && in_ready_o[i]) begin
          hold_v_d[i] = 1'b1;
          capture[i]  = 1'b1;
        end else if (take[i]) begin
          hold_v_d[i] = 1'b0;
        end
      end
      if (take_any) begin
        rr_ptr_d = (sel == LANE_W'(SIZE - 1)) ? '0 : sel + LANE_W'(1);
      end
    end
  end

  // pending_o shows the occupancy that holds after the edge, so it always
  // matches hold_v_q.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < SIZE; i++) begin
      pending_d = pending_d + CNT_W'(hold_v_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hold_v_q  <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      hold_v_q  <= hold_v_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

  // The payload registers are only read while their valid bit is set, so
  // they do not need a reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SIZE; i++) begin
      if (capture[i]) begin
        hold_tag_q[i]  <= in_tag_i[i];
        hold_data_q[i] <= in_data_i[i];
      end
    end
  end

  assign pending_o = pending_q;

endmodule
